// File: rtl/usr_seq_pkg.sv
// Shared definitions for the USR shift sequencer: widths, USR op codes,
// sequencer state encoding and the bit-count normalisation helper.
package usr_seq_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int COUNT_WIDTH = 6;

  localparam logic [1:0] OP_NO_OP = 2'd0;
  localparam logic [1:0] OP_LEFT  = 2'd1;
  localparam logic [1:0] OP_RIGHT = 2'd2;
  localparam logic [1:0] OP_LOAD  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_CAPTURE,
    ST_DONE
  } seq_state_e;

  // A count of 0, or one wider than the register, means a full-width transfer.
  function automatic logic [COUNT_WIDTH-1:0] normalise_count(input logic [COUNT_WIDTH-1:0] n);
    if ((n == '0) || (n > COUNT_WIDTH'(DATA_WIDTH))) return COUNT_WIDTH'(DATA_WIDTH);
    return n;
  endfunction

endpackage

// File: rtl/usr_shift_sequencer_if.sv
// Word-level client port of the USR shift sequencer: start handshake,
// receive handshake and busy status.
interface usr_shift_sequencer_if;
  import usr_seq_pkg::*;

  logic                   Start_Valid_In;
  logic                   Start_Ready_Out;
  logic [DATA_WIDTH-1:0]  Tx_Data_In;
  logic [COUNT_WIDTH-1:0] Bit_Count_In;
  logic                   Direction_In;
  logic [DATA_WIDTH-1:0]  Rx_Data_Out;
  logic                   Rx_Valid_Out;
  logic                   Rx_Ready_In;
  logic                   Busy_Out;

  modport master (
    output Start_Valid_In, Tx_Data_In, Bit_Count_In, Direction_In, Rx_Ready_In,
    input  Start_Ready_Out, Rx_Data_Out, Rx_Valid_Out, Busy_Out
  );

  modport slave (
    input  Start_Valid_In, Tx_Data_In, Bit_Count_In, Direction_In, Rx_Ready_In,
    output Start_Ready_Out, Rx_Data_Out, Rx_Valid_Out, Busy_Out
  );

endinterface

// File: rtl/usr_seq_bit_counter.sv
// Remaining-shift counter: loads a normalised bit count, decrements once per
// shift cycle and flags the final shift.
module usr_seq_bit_counter
  import usr_seq_pkg::*;
(
  input  logic                   Clk_In,
  input  logic                   Reset_In,
  input  logic                   Load_In,
  input  logic                   Decrement_In,
  input  logic [COUNT_WIDTH-1:0] Count_In,
  output logic                   Last_Out
);

  logic [COUNT_WIDTH-1:0] count_q;

  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      count_q <= '0;
    end else if (Load_In) begin
      count_q <= normalise_count(Count_In);
    end else if (Decrement_In && (count_q != '0)) begin
      count_q <= count_q - COUNT_WIDTH'(1);
    end
  end

  assign Last_Out = (count_q == COUNT_WIDTH'(1));

endmodule

// File: rtl/usr_shift_sequencer.sv
// Sequencer driving a negedge-sampling USR through load, N shifts and capture.
// Optional feature macro: USR_SEQ_LOOPBACK_EN adds Loopback_In (internal serial loopback).
module usr_shift_sequencer
  import usr_seq_pkg::*;
(
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  usr_shift_sequencer_if.slave  client,
  input  logic                  Serial_Line_In,
  output logic                  Serial_Line_Out,
  output logic                  USR_Enable_Out,
  output logic [1:0]            USR_Operation_Select_Out,
  output logic [DATA_WIDTH-1:0] USR_Parallel_Data_Out,
  output logic                  USR_Serial_Left_Side_Data_Out,
  output logic                  USR_Serial_Right_Side_Data_Out,
  input  logic [DATA_WIDTH-1:0] USR_Parallel_Data_In,
  input  logic                  USR_Serial_Left_Side_Data_In,
  input  logic                  USR_Serial_Right_Side_Data_In
`ifdef USR_SEQ_LOOPBACK_EN
  ,
  input  logic                  Loopback_In
`endif
);

  seq_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0]  tx_q, rx_q, rx_aligned;
  logic [COUNT_WIDTH-1:0] n_q, pad;
  logic                   dir_q, rx_valid_q, ser_out_q;
  logic                   accept, shift_last, feed_bit;

  assign accept = client.Start_Valid_In && (state_q == ST_IDLE);

  usr_seq_bit_counter u_bit_counter (
    .Clk_In       (Clk_In),
    .Reset_In     (Reset_In),
    .Load_In      (accept),
    .Decrement_In (state_q == ST_SHIFT),
    .Count_In     (client.Bit_Count_In),
    .Last_Out     (shift_last)
  );

`ifdef USR_SEQ_LOOPBACK_EN
  assign feed_bit = Loopback_In ? ser_out_q : Serial_Line_In;
`else
  assign feed_bit = Serial_Line_In;
`endif

  // NOTE: every always_comb output gets a default first, so no branch can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (accept) state_d = ST_LOAD;
      ST_LOAD:    state_d = ST_SHIFT;
      ST_SHIFT:   if (shift_last) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_DONE;
      ST_DONE:    if (client.Rx_Ready_In) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    USR_Enable_Out                 = 1'b0;
    USR_Operation_Select_Out       = OP_NO_OP;
    USR_Parallel_Data_Out          = '0;
    USR_Serial_Left_Side_Data_Out  = 1'b0;
    USR_Serial_Right_Side_Data_Out = 1'b0;
    case (state_q)
      ST_LOAD: begin
        USR_Enable_Out           = 1'b1;
        USR_Operation_Select_Out = OP_LOAD;
        USR_Parallel_Data_Out    = tx_q;
      end
      ST_SHIFT: begin
        USR_Enable_Out = 1'b1;
        if (dir_q) begin
          USR_Operation_Select_Out      = OP_RIGHT;
          USR_Serial_Left_Side_Data_Out = feed_bit;
        end else begin
          USR_Operation_Select_Out       = OP_LEFT;
          USR_Serial_Right_Side_Data_Out = feed_bit;
        end
      end
      ST_CAPTURE: USR_Enable_Out = 1'b1;
      default: ;
    endcase
  end

  // Received bits sit at the low end after a left shift and at the top after
  // a right shift; both are brought to a right-justified N-bit value.
  assign pad        = COUNT_WIDTH'(DATA_WIDTH) - n_q;
  assign rx_aligned = dir_q ? (USR_Parallel_Data_In >> pad)
                            : (USR_Parallel_Data_In & ({DATA_WIDTH{1'b1}} >> pad));

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q    <= ST_IDLE;
      tx_q       <= '0;
      n_q        <= '0;
      dir_q      <= 1'b0;
      rx_q       <= '0;
      rx_valid_q <= 1'b0;
      ser_out_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        tx_q  <= client.Tx_Data_In;
        n_q   <= normalise_count(client.Bit_Count_In);
        dir_q <= client.Direction_In;
      end
      // The USR moves at negedge, so registering its edge bit here holds each
      // outgoing bit for one whole shift cycle.
      ser_out_q <= (state_d == ST_SHIFT)
                   ? (dir_q ? USR_Serial_Right_Side_Data_In : USR_Serial_Left_Side_Data_In)
                   : 1'b0;
      if (state_q == ST_CAPTURE) begin
        rx_q       <= rx_aligned;
        rx_valid_q <= 1'b1;
      end else if ((state_q == ST_DONE) && client.Rx_Ready_In) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign Serial_Line_Out        = ser_out_q;
  assign client.Rx_Data_Out     = rx_q;
  assign client.Rx_Valid_Out    = rx_valid_q;
  assign client.Busy_Out        = (state_q != ST_IDLE);
  assign client.Start_Ready_Out = (state_q == ST_IDLE) && !Reset_In;

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Scoreboard bench for usr_shift_sequencer with a behavioural negedge USR;
// directed transfers cover both directions, count normalisation, back-pressure and reset.
module tb_usr_shift_sequencer;
  import usr_seq_pkg::*;

  typedef struct {
    logic [31:0] rx;
    int          n;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  usr_shift_sequencer_if bus();

  logic        serial_in_drv = 1'b0;
  logic        loop_en = 1'b0;
  logic        serial_in, serial_out;
  logic        usr_en, usr_sl_out, usr_sr_out;
  logic [1:0]  usr_op;
  logic [31:0] usr_par_out;
  logic [31:0] usr_q;

  assign serial_in = loop_en ? serial_out : serial_in_drv;

  usr_shift_sequencer dut (
    .Clk_In                         (clk),
    .Reset_In                       (rst),
    .client                         (bus),
    .Serial_Line_In                 (serial_in),
    .Serial_Line_Out                (serial_out),
    .USR_Enable_Out                 (usr_en),
    .USR_Operation_Select_Out       (usr_op),
    .USR_Parallel_Data_Out          (usr_par_out),
    .USR_Serial_Left_Side_Data_Out  (usr_sl_out),
    .USR_Serial_Right_Side_Data_Out (usr_sr_out),
    .USR_Parallel_Data_In           (usr_q),
    .USR_Serial_Left_Side_Data_In   (usr_q[31]),
    .USR_Serial_Right_Side_Data_In  (usr_q[0])
`ifdef USR_SEQ_LOOPBACK_EN
    ,
    .Loopback_In                    (loop_en)
`endif
  );

  // Behavioural USR: samples controls on the falling edge.
  always @(negedge clk or posedge rst) begin
    if (rst) usr_q <= '0;
    else if (usr_en) begin
      case (usr_op)
        OP_LEFT:  usr_q <= {usr_q[30:0], usr_sr_out};
        OP_RIGHT: usr_q <= {usr_sl_out, usr_q[31:1]};
        OP_LOAD:  usr_q <= usr_par_out;
        default:  usr_q <= usr_q;
      endcase
    end
  end

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   shift_cnt = 0;
  exp_t exp_q[$];
  bit   exp_ser_q[$];
  bit   feed_q[$];
  logic rx_valid_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: required event did not occur (t=%0t)", name, $time);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: checks each serial bit, feeds the line, and scores Rx on valid rise.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (!rst && (usr_op == OP_LEFT || usr_op == OP_RIGHT)) begin
      shift_cnt++;
      if (exp_ser_q.size() == 0) fail("serial_unexpected");
      else check("serial_out", 32'(serial_out), 32'(exp_ser_q.pop_front()));
      serial_in_drv = (feed_q.size() != 0) ? feed_q.pop_front() : 1'b0;
    end else begin
      serial_in_drv = 1'b0;
    end
    if (bus.Rx_Valid_Out && !rx_valid_prev) begin
      if (exp_q.size() == 0) fail("rx_unexpected");
      else begin
        e = exp_q.pop_front();
        check("rx_data", bus.Rx_Data_Out, e.rx);
        check("rx_latency", 32'(cyc - e.acc), 32'(e.n + 2));
        check("shift_cycles", 32'(shift_cnt), 32'(e.n));
      end
    end
    rx_valid_prev = bus.Rx_Valid_Out;
  end

  // Push nb bits of v, listed first-to-last from v[nb-1] down to v[0].
  task automatic push_ser(input logic [31:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) exp_ser_q.push_back(v[i]);
  endtask

  task automatic push_feed(input logic [31:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) feed_q.push_back(v[i]);
  endtask

  task automatic start_xfer(input logic [31:0] tx, input logic [5:0] cnt, input logic dir,
                            input int n, input logic [31:0] rx, output int acc);
    exp_t e;
    int   t;
    t   = 0;
    acc = -1;
    @(negedge clk);
    bus.Tx_Data_In     = tx;
    bus.Bit_Count_In   = cnt;
    bus.Direction_In   = dir;
    bus.Start_Valid_In = 1'b1;
    while (!bus.Start_Ready_Out && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      fail("start_accept_timeout");
      bus.Start_Valid_In = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acc       = cyc;
      shift_cnt = 0;
      e.rx  = rx;
      e.n   = n;
      e.acc = acc;
      exp_q.push_back(e);
      bus.Start_Valid_In = 1'b0;
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    @(negedge clk);
    while ((bus.Busy_Out || bus.Rx_Valid_Out || exp_q.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) fail("transfer_timeout");
    check("ser_queue_empty", 32'(exp_ser_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start_ready"}, 32'(bus.Start_Ready_Out), 32'd0);
    check({tag, "_rx_valid"}, 32'(bus.Rx_Valid_Out), 32'd0);
    check({tag, "_rx_data"}, bus.Rx_Data_Out, 32'd0);
    check({tag, "_busy"}, 32'(bus.Busy_Out), 32'd0);
    check({tag, "_usr_en"}, 32'(usr_en), 32'd0);
    check({tag, "_usr_op"}, 32'(usr_op), 32'd0);
    check({tag, "_usr_par"}, usr_par_out, 32'd0);
    check({tag, "_usr_sl"}, 32'(usr_sl_out), 32'd0);
    check({tag, "_usr_sr"}, 32'(usr_sr_out), 32'd0);
    check({tag, "_serial_out"}, 32'(serial_out), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int          acc;
    int          t;
    int          e_cyc;
    logic [31:0] tx3;
    bus.Start_Valid_In = 1'b0;
    bus.Tx_Data_In     = '0;
    bus.Bit_Count_In   = '0;
    bus.Direction_In   = 1'b0;
    bus.Rx_Ready_In    = 1'b1;

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(bus.Start_Ready_Out), 32'd1);

    // Left shift, N=8.
    push_ser(32'hA5, 8);
    push_feed(32'h3C, 8);
    start_xfer(32'hA500_0000, 6'd8, 1'b0, 8, 32'h0000_003C, acc);
    wait_done();

    // Right shift, N=4.
    push_ser(32'b0011, 4);
    push_feed(32'b1001, 4);
    start_xfer(32'h0000_000C, 6'd4, 1'b1, 4, 32'h0000_0009, acc);
    wait_done();

    // Right shift, N=1.
    push_ser(32'b1, 1);
    push_feed(32'b1, 1);
    start_xfer(32'h0000_0003, 6'd1, 1'b1, 1, 32'h0000_0001, acc);
    wait_done();

    // Count 0 -> 32, right shift with the line looped back: a full rotation.
    tx3 = 32'h1234_5678;
    for (int i = 0; i < 32; i++) exp_ser_q.push_back(tx3[i]);
    loop_en = 1'b1;
    start_xfer(tx3, 6'd0, 1'b1, 32, 32'h1234_5678, acc);
    wait_done();
    loop_en = 1'b0;

    // Count 40 -> 32, left shift.
    push_ser(32'hFFFF_0000, 32);
    push_feed(32'hDEAD_BEEF, 32);
    start_xfer(32'hFFFF_0000, 6'd40, 1'b0, 32, 32'hDEAD_BEEF, acc);
    wait_done();

    // Back-pressure: Rx_Ready_In low, next request already waiting.
    bus.Rx_Ready_In = 1'b0;
    push_ser(32'b11, 2);
    push_feed(32'b10, 2);
    start_xfer(32'hC000_0000, 6'd2, 1'b0, 2, 32'h0000_0002, acc);
    bus.Tx_Data_In     = 32'h0000_0005;
    bus.Bit_Count_In   = 6'd3;
    bus.Direction_In   = 1'b1;
    bus.Start_Valid_In = 1'b1;
    t = 0;
    while (!bus.Rx_Valid_Out && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) fail("bp_rx_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      check("bp_rx_data_hold", bus.Rx_Data_Out, 32'h0000_0002);
      check("bp_rx_valid_hold", 32'(bus.Rx_Valid_Out), 32'd1);
      check("bp_start_ready_low", 32'(bus.Start_Ready_Out), 32'd0);
      @(negedge clk);
    end
    bus.Rx_Ready_In = 1'b1;
    @(posedge clk);
    #1;
    e_cyc = cyc;
    check("bp_idle_busy", 32'(bus.Busy_Out), 32'd0);
    check("bp_idle_rx_valid", 32'(bus.Rx_Valid_Out), 32'd0);
    push_ser(32'b101, 3);
    push_feed(32'b011, 3);
    start_xfer(32'h0000_0005, 6'd3, 1'b1, 3, 32'h0000_0006, acc);
    check("bp_second_accept_edge", 32'(acc - e_cyc), 32'd1);
    wait_done();

    // Reset at the third shift cycle, then a normal transfer.
    push_ser(32'hA5, 8);
    push_feed(32'h3C, 8);
    start_xfer(32'hA500_0000, 6'd8, 1'b0, 8, 32'h0000_003C, acc);
    t = 0;
    while (shift_cnt < 3 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) fail("reset_shift_wait_timeout");
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    exp_ser_q.delete();
    feed_q.delete();
    @(negedge clk);
    rst = 1'b0;
    push_ser(32'hA5, 8);
    push_feed(32'h3C, 8);
    start_xfer(32'hA500_0000, 6'd8, 1'b0, 8, 32'h0000_003C, acc);
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usr_shift_sequencer.md
# usr_shift_sequencer

Sequencing controller for the 32-bit universal shift register (USR) used as a serial transceiver. It accepts a transmit word and bit count via a valid/ready handshake. It then drives the USR through a parallel load, N serial shifts and a capture, and returns the received bits right-justified via a second valid/ready handshake. It sits between a word-level client and a single USR instance.

## Interface
- DATA_WIDTH, 32, USR width; fixed at 32 for this release
- COUNT_WIDTH, 6, width of bit count and internal counter
- Clk_In  in  1  clock; sequencer state updates on posedge
- Reset_In  in  1  reset, asynchronous, active-high
- Start_Valid_In  in  1  transfer request
- Start_Ready_Out  out  1  high only in IDLE
- Tx_Data_In  in  32  word to transmit
- Bit_Count_In  in  6  bits to shift; 0 or >32 means 32
- Direction_In  in  1  0 = shift left (MSB first), 1 = shift right (LSB first)
- Rx_Data_Out  out  32  received bits, right-justified
- Rx_Valid_Out  out  1  Rx_Data_Out valid
- Rx_Ready_In  in  1  client accepts Rx_Data_Out
- Busy_Out  out  1  high in any state except IDLE
- Serial_Line_In  in  1  incoming serial bit
- Serial_Line_Out  out  1  outgoing serial bit
- USR_Enable_Out  out  1  to USR Enable_In
- USR_Operation_Select_Out  out  2  to USR op select
- USR_Parallel_Data_Out  out  32  to USR parallel input
- USR_Serial_Left_Side_Data_Out / USR_Serial_Right_Side_Data_Out  out  1 each  to USR serial inputs
- USR_Parallel_Data_In  in  32  from USR parallel output
- USR_Serial_Left_Side_Data_In / USR_Serial_Right_Side_Data_In  in  1 each  from USR serial outputs (bit 31 / bit 0)

## Operation
- USR shares Clk_In and Reset_In. The USR samples on negedge, so controls set at posedge are stable for a half cycle before use.
- Op codes: NO_OP 0, LEFT 1, RIGHT 2, LOAD 3.
- States:
  - IDLE: Start_Ready_Out=1, USR_Enable_Out=0, op=NO_OP. On Start_Valid_In & Start_Ready_Out, latch Tx, count N (normalised) and direction, then go to LOAD.
  - LOAD: enable=1, op=LOAD, USR_Parallel_Data_Out=latched Tx. Next state is SHIFT, with counter=N.
  - SHIFT: enable=1, op=LEFT or RIGHT. Counter decrements each cycle; at counter=1, go to CAPTURE.
  - CAPTURE: enable=1, op=NO_OP. Register the aligned USR_Parallel_Data_In into Rx_Data_Out, set Rx_Valid_Out, go to DONE.
  - DONE: enable=0. Hold Rx_Data_Out and Rx_Valid_Out until Rx_Ready_In, then clear Rx_Valid_Out and go to IDLE.
- Left shift:
  - Serial_Line_Out = USR_Serial_Left_Side_Data_In.
  - USR_Serial_Right_Side_Data_Out = Serial_Line_In; left-side serial out = 0.
  - Rx = USR value masked to its low N bits.
- Right shift:
  - Serial_Line_Out = USR_Serial_Right_Side_Data_In.
  - USR_Serial_Left_Side_Data_Out = Serial_Line_In; right-side serial out = 0.
  - Rx = USR value logically shifted right by 32−N.
- Serial_Line_Out is 0 outside SHIFT.
- Start_Valid_In is ignored outside IDLE. Tx_Data_In is sampled only at acceptance.
- Rx_Ready_In is ignored outside DONE.

## Timing
- Reset values: state IDLE, Start_Ready_Out=0 while Reset_In is high and 1 after, Rx_Data_Out=0, Rx_Valid_Out=0, Busy_Out=0, all USR_* outputs 0, Serial_Line_Out=0.
- Handshake accepted at edge k:
  - LOAD occupies cycle k..k+1.
  - SHIFT occupies N cycles.
  - CAPTURE follows.
  - Rx_Valid_Out rises at edge k+N+2.
- Serial timing: each serial bit is presented on Serial_Line_Out for one full SHIFT cycle. Serial_Line_In must be stable at that cycle's negedge.
- Rx_Ready_In high when Rx_Valid_Out rises: DONE→IDLE at the next edge. Minimum transfer period is N+4 cycles.
- Reset_In mid-transfer: immediate return to IDLE with all outputs at reset values. Any partial Rx is discarded.

## Configuration
- USR_SEQ_LOOPBACK_EN defined:
  - Adds port Loopback_In (in, 1).
  - When Loopback_In is high during SHIFT, the bit fed to the USR serial input is Serial_Line_Out instead of Serial_Line_In.
  - Serial_Line_Out is still driven.
- Macro undefined: port absent; Serial_Line_In is always used.

## Structure
- Package usr_seq_pkg holds:
  - op-code localparams (NO_OP/LEFT/RIGHT/LOAD)
  - state encoding (IDLE, LOAD, SHIFT, CAPTURE, DONE)
  - DATA_WIDTH/COUNT_WIDTH defaults
- One sub-module, usr_seq_bit_counter, provides load with normalisation (0 or >32 → 32), decrement, and a last-bit flag.

## Test plan
- Left shift:
  - Stimulus: N=8, Tx=0xA5000000, line fed 0,0,1,1,1,1,0,0.
  - Required: Serial_Line_Out = 1,0,1,0,0,1,0,1; Rx_Data_Out=0x0000003C; Rx_Valid_Out rises 10 edges after acceptance.
- Right shift:
  - Stimulus: N=4, Tx=0x0000000C, line fed 1,0,0,1.
  - Required: Serial_Line_Out = 0,0,1,1; Rx_Data_Out=0x00000009.
- Bit count normalisation (N=0 treated as 32):
  - Stimulus: Bit_Count_In=0, loopback on (USR_SEQ_LOOPBACK_EN), right shift, Tx=0x12345678.
  - Required: exactly 32 SHIFT cycles; Rx_Data_Out=0x12345678.
- Handshake back-pressure:
  - Stimulus: Rx_Ready_In held low for 5 cycles, then raised; Start_Valid_In held high throughout.
  - Required: Rx_Data_Out stable and Start_Ready_Out=0 throughout; second transfer accepted one edge after DONE→IDLE.
- Reset mid-SHIFT:
  - Stimulus: Reset_In pulsed at the 3rd shift.
  - Required: all outputs return to reset values asynchronously; the next transfer completes normally with the correct Rx.
